// File: rtl/dmem_responder.sv
`default_nettype none
//==============================================================================
// Module   : dmem_responder
// Purpose  : Target end of the core's data-memory interface. Accepts one read
//            or write at a time, waits LATENCY cycles, then pulses ready for
//            one cycle. Writes are byte/halfword/word into a 32-bit word
//            array; reads return the whole aligned word.
// Ports    : clk           - clock, rising edge
//            reset         - asynchronous reset, active low
//            dmem_addr     - byte address
//            dmem_r_enable - read request, held until ready
//            dmem_w_enable - write request, held until ready (wins over read)
//            dmem_w_size   - 00 byte, 01 half, 10/11 word
//            dmem_w_data   - right-aligned write data
//            dmem_r_data   - registered aligned read word
//            dmem_ready    - one-cycle completion pulse
//            dmem_err      - misalignment flag with ready
//                            (only with DMEM_MISALIGN_TRAP_EN defined)
// Options  : DMEM_MISALIGN_TRAP_EN - misaligned half/word accesses complete
//            without effect and raise dmem_err instead of being force-aligned.
// Revision : 1.0 - initial release
//==============================================================================

`ifndef ADDR_SIZE
`define ADDR_SIZE 31
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 31
`endif

module dmem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [`ADDR_SIZE:0]  dmem_addr,
  input  logic                 dmem_r_enable,
  input  logic                 dmem_w_enable,
  input  logic [1:0]           dmem_w_size,
  input  logic [`INSTR_SIZE:0] dmem_w_data,
  output logic [`INSTR_SIZE:0] dmem_r_data,
`ifdef DMEM_MISALIGN_TRAP_EN
  output logic                 dmem_err,
`endif
  output logic                 dmem_ready
);

  localparam int         DEPTH  = 1 << DEPTH_LOG2;
  localparam int         AW     = DEPTH_LOG2 + 2;
  localparam logic [3:0] C_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                 r_state;
  logic [3:0]             r_count;
  logic [AW-1:0]          r_addr;
  logic [`INSTR_SIZE:0]   r_wdata;
  logic [1:0]             r_wsize;
  logic                   r_is_write;
  logic                   r_ready;
  logic [`INSTR_SIZE:0]   r_rdata;
  logic [`INSTR_SIZE:0]   r_mem [0:DEPTH-1];

  logic [DEPTH_LOG2-1:0]  w_cap_index;
  logic [DEPTH_LOG2-1:0]  w_live_index;
  logic                   w_mis_cap;
  logic                   w_mis_live;
  logic [3:0]             w_be;
  logic [`INSTR_SIZE:0]   w_lane_data;
  logic [`INSTR_SIZE:0]   w_bit_mask;
  logic                   w_do_write;
  logic                   w_unused_addr_hi;

  // Upper address bits select nothing: the array wraps modulo DEPTH words.
  assign w_unused_addr_hi = ^dmem_addr[`ADDR_SIZE:AW];
  assign w_cap_index      = r_addr[AW-1:2];
  assign w_live_index     = dmem_addr[AW-1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
  logic r_err;

  function automatic logic f_misaligned(input logic [1:0] a, input logic [1:0] sz);
    return ((sz == 2'b01) && a[0]) || (sz[1] && (a != 2'b00));
  endfunction

  assign w_mis_cap  = f_misaligned(r_addr[1:0], r_wsize);
  assign w_mis_live = f_misaligned(dmem_addr[1:0], dmem_w_size);
  assign dmem_err   = r_err;
`else
  assign w_mis_cap  = 1'b0;
  assign w_mis_live = 1'b0;
`endif

  // Data is replicated across lanes so the byte enables alone pick the target
  // lanes; half ignores addr[0] and word ignores addr[1:0] (forced alignment).
  always_comb begin
    w_be        = 4'b1111;
    w_lane_data = r_wdata;
    case (r_wsize)
      2'b00: begin
        w_be        = 4'b0001 << r_addr[1:0];
        w_lane_data = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be        = r_addr[1] ? 4'b1100 : 4'b0011;
        w_lane_data = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be        = 4'b1111;
        w_lane_data = r_wdata;
      end
    endcase
  end

  assign w_bit_mask = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};

  // The write commits on the edge that ends RESP; a reset during the request
  // leaves the FSM outside RESP, so the write is dropped.
  assign w_do_write = (r_state == S_RESP) && r_is_write && !w_mis_cap;

  always_ff @(posedge clk) begin
    if (w_do_write) begin
      r_mem[w_cap_index] <= (r_mem[w_cap_index] & ~w_bit_mask) | (w_lane_data & w_bit_mask);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_count    <= 4'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wsize    <= 2'b00;
      r_is_write <= 1'b0;
      r_ready    <= 1'b0;
      r_rdata    <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
      r_err      <= 1'b0;
`endif
    end else begin
      r_ready <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      r_err   <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (dmem_r_enable || dmem_w_enable) begin
            r_addr     <= dmem_addr[AW-1:0];
            r_wdata    <= dmem_w_data;
            r_wsize    <= dmem_w_size;
            r_is_write <= dmem_w_enable;
            r_count    <= C_LOAD;
            if (LATENCY == 1) begin
              // Captured registers are not valid yet, so use the live inputs.
              r_state <= S_RESP;
              r_ready <= 1'b1;
              if (!dmem_w_enable && !w_mis_live) begin
                r_rdata <= r_mem[w_live_index];
              end
`ifdef DMEM_MISALIGN_TRAP_EN
              r_err <= w_mis_live;
`endif
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_count <= r_count - 4'd1;
          if (r_count <= 4'd1) begin
            r_state <= S_RESP;
            r_ready <= 1'b1;
            if (!r_is_write && !w_mis_cap) begin
              r_rdata <= r_mem[w_cap_index];
            end
`ifdef DMEM_MISALIGN_TRAP_EN
            r_err <= w_mis_cap;
`endif
          end
        end
        S_RESP: begin
          // Never accept here: the finishing request's enable is still high.
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign dmem_ready  = r_ready;
  assign dmem_r_data = r_rdata;

endmodule

`default_nettype wire
